// File: rtl/fetch_mem_if.sv
// -----------------------------------------------------------------------------
// fetch_mem_if
// Instruction-memory front end for the fetch stage. It reads the instruction at
// pc_f over a req/ack memory port and registers it into the F->D boundary. It
// copes with variable memory latency, decode back-pressure and branch/jump
// flushes, and drives fetch_stall so that the hazard unit can hold the fetch PC
// register.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   pc_f             current PC from the fetch PC register
//   flush_f          redirect: squash fetch, PC register loads the target
//   dec_stall        decode cannot accept an instruction this cycle
//   mem_req/addr     read request to instruction memory
//   mem_ack/rdata    one-cycle completion pulse with the instruction word
//   instr_d          registered instruction to decode
//   pc_plus4_d       registered PC+4 of instr_d
//   instr_valid_d    instr_d is real (0 = bubble)
//   fetch_stall      hold the fetch PC register (combinational)
// -----------------------------------------------------------------------------
module fetch_mem_if #(
   parameter int unsigned        ADDR_W = 32,
   parameter int unsigned        DATA_W = 32,
   parameter logic [DATA_W-1:0]  NOP    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_f,
   input  logic              flush_f,
   input  logic              dec_stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr_d,
   output logic [ADDR_W-1:0] pc_plus4_d,
   output logic              instr_valid_d,
   output logic              fetch_stall
);

   typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

   state_e            state_q;
   logic [DATA_W-1:0] hold_q;
   logic [ADDR_W-1:0] hold_pc_q;
   logic [ADDR_W-1:0] drop_addr_q;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] pc_plus4_q;
   logic              valid_q;

   logic              accept;
   logic [ADDR_W-1:0] pc_next;

   // Wraps at 2^ADDR_W; carry-out is dropped.
   assign pc_next = pc_f + ADDR_W'(4);

   assign accept = ((state_q == StReq && mem_ack) || state_q == StHold)
                   && !dec_stall && !flush_f;

   assign mem_req  = (state_q == StReq) || (state_q == StDrop);
   // An abandoned request must still complete at its original address.
   assign mem_addr = (state_q == StDrop) ? drop_addr_q : pc_f;

   // IDLE and DROP never let the PC advance, even when a flush is raised.
   assign fetch_stall = (state_q == StIdle) || (state_q == StDrop) || !(accept || flush_f);

   assign instr_d       = instr_q;
   assign pc_plus4_d    = pc_plus4_q;
   assign instr_valid_d = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_pc_q   <= '0;
         drop_addr_q <= '0;
         instr_q     <= NOP;
         pc_plus4_q  <= '0;
         valid_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StReq;
            StReq: begin
               if (flush_f) begin
                  // With ack the stale word is simply dropped; without it the
                  // outstanding read has to be drained first.
                  if (!mem_ack) begin
                     drop_addr_q <= pc_f;
                     state_q     <= StDrop;
                  end
               end else if (mem_ack && dec_stall) begin
                  hold_q    <= mem_rdata;
                  hold_pc_q <= pc_next;
                  state_q   <= StHold;
               end
            end
            StHold: begin
               if (flush_f || !dec_stall) state_q <= StReq;
            end
            StDrop: begin
               if (mem_ack) state_q <= StReq;
            end
            default: state_q <= StIdle;
         endcase

         // F->D register, in priority order: flush, stall, accept, bubble.
         if (flush_f) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
         end else if (dec_stall) begin
            instr_q <= instr_q;
         end else if (accept) begin
            if (state_q == StHold) begin
               instr_q    <= hold_q;
               pc_plus4_q <= hold_pc_q;
            end else begin
               instr_q    <= mem_rdata;
               pc_plus4_q <= pc_next;
            end
            valid_q <= 1'b1;
         end else begin
            instr_q <= NOP;
            valid_q <= 1'b0;
         end
      end
   end

endmodule
